// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, fixed latency.
// Divide-by-zero completes immediately with an all-ones quotient and dbz set.
module seq_divider #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Q,
  output logic [DATA_W-1:0] R,
  output logic              busy,
  output logic              fin,
  output logic              dbz
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   div;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] step;

  // One restoring step on {rem, quo}; the extra subtraction bit carries the borrow.
  // The shifted remainder is below 2*div, so DATA_W+1 bits always hold it.
  function automatic logic [2*DATA_W-1:0] restore_step(
    input logic [DATA_W-1:0] rem_in,
    input logic [DATA_W-1:0] quo_in,
    input logic [DATA_W-1:0] div_in
  );
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    shifted = {rem_in, quo_in[DATA_W-1]};
    diff    = {1'b0, shifted} - {2'b00, div_in};
    if (diff[DATA_W+1])
      return {shifted[DATA_W-1:0], quo_in[DATA_W-2:0], 1'b0};
    else
      return {diff[DATA_W-1:0], quo_in[DATA_W-2:0], 1'b1};
  endfunction

  assign step = restore_step(rem, quo, div);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      quo   <= '0;
      rem   <= '0;
      div   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      fin   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fin <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (B != '0) begin
              quo   <= A;
              div   <= B;
              rem   <= '0;
              cnt   <= '0;
              dbz   <= 1'b0;
              state <= RUN;
            end else begin
              Q     <= '1;
              R     <= A;
              dbz   <= 1'b1;
              fin   <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          {rem, quo} <= step;
          cnt        <= cnt + CNT_W'(1);
          // Outputs only move on the final step so Q/R stay stable while running.
          if (cnt == CNT_W'(DATA_W - 1)) begin
            Q     <= step[DATA_W-1:0];
            R     <= step[2*DATA_W-1:DATA_W];
            fin   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          fin   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences and an
// exhaustive-dividend sweep, with results matched through a scoreboard queue.
module tb_seq_divider;

  logic       CLK = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       fin;
  logic       dbz;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  seq_divider dut (
    .CLK   (CLK),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .fin   (fin),
    .dbz   (dbz)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every fin pulse must match the oldest pending request.
  always @(negedge CLK) begin
    if (fin) begin
      if (sb.size() == 0) begin
        check("fin_unexpected", int'(fin), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("Q", int'(Q), int'(e.q));
        check("R", int'(R), int'(e.r));
        check("dbz", int'(dbz), int'(e.dbz));
      end
    end
  end

  // Issue one operation from IDLE and check latency, pulse width and output hold.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ed);
    int         lat;
    bit         seen;
    bit         moved;
    logic [7:0] q0;
    logic [7:0] r0;
    exp_t       e;
    @(negedge CLK);
    q0 = Q;
    r0 = R;
    A = a;
    B = b;
    start = 1'b1;
    e.q = eq;
    e.r = er;
    e.dbz = ed;
    sb.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    A = ~a;
    B = ~b;
    lat = 1;
    seen = 0;
    moved = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fin) seen = 1;
      else begin
        if (Q !== q0 || R !== r0) moved = 1;
        @(negedge CLK);
        lat++;
      end
    end
    check("latency", seen ? lat : -1, (b == 8'd0) ? 1 : 9);
    check("qr_hold_run", int'(moved), 0);
    check("busy_at_fin", int'(busy), 1);
    @(negedge CLK);
    check("fin_one_cycle", int'(fin), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  vec_t vecs[9];
  logic [7:0] blist[6];

  initial begin
    int fin_cnt;
    int fin_at[$];
    rst = 1'b1;
    start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    vecs[0] = {8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1] = {8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = {8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3] = {8'd200, 8'd0,   8'hFF,  8'd200, 1'b1};
    vecs[4] = {8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[5] = {8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[6] = {8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[7] = {8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
    vecs[8] = {8'd37,  8'd128, 8'd0,   8'd37,  1'b0};
    blist = '{8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd255};

    repeat (2) @(negedge CLK);
    check("rst_Q", int'(Q), 0);
    check("rst_R", int'(R), 0);
    check("rst_fin", int'(fin), 0);
    check("rst_dbz", int'(dbz), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Results hold in IDLE after completion.
    repeat (3) @(negedge CLK);
    check("hold_Q", int'(Q), 0);
    check("hold_R", int'(R), 37);

    // start held high; operands change mid-run; second request waits for IDLE.
    @(negedge CLK);
    A = 8'd100;
    B = 8'd7;
    start = 1'b1;
    sb.push_back(exp_t'{8'd14, 8'd2, 1'b0});
    sb.push_back(exp_t'{8'd16, 8'd2, 1'b0});
    @(negedge CLK);
    A = 8'd50;
    B = 8'd3;
    for (int c = 1; c <= 30; c++) begin
      if (fin) fin_at.push_back(c);
      if (c == 10) check("busy_gap", int'(busy), 0);
      if (c == 11) start = 1'b0;
      @(negedge CLK);
    end
    check("b2b_fin_count", fin_at.size(), 2);
    if (fin_at.size() == 2) begin
      check("b2b_first", fin_at[0], 9);
      check("b2b_interval", fin_at[1] - fin_at[0], 10);
    end

    // Reset at RUN step 4 aborts without a completion pulse.
    @(negedge CLK);
    A = 8'd100;
    B = 8'd7;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    check("abort_Q", int'(Q), 0);
    check("abort_R", int'(R), 0);
    check("abort_busy", int'(busy), 0);
    fin_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (fin) fin_cnt++;
      @(negedge CLK);
    end
    check("abort_no_fin", fin_cnt, 0);
    do_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

    // Every dividend against a set of boundary divisors.
    for (int bi = 0; bi < 6; bi++)
      for (int a = 0; a < 256; a++)
        do_op(8'(a), blist[bi], 8'(a / int'(blist[bi])), 8'(a % int'(blist[bi])), 1'b0);

    repeat (2) @(negedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
